// File: rtl/hex_disp_arb.sv
// Round-robin arbiter that gives four requesters turns at a 4-digit hex display write port.
// Define HEX_DISP_ARB_PRIO_EN to let requester 0 preempt other owners and win every IDLE tie.
module hex_disp_arb #(
  parameter int unsigned DWELL_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  i_req,
  input  logic [63:0] i_data,
  output logic [15:0] o_data,
  output logic        o_we,
  output logic [3:0]  o_gnt,
  output logic [1:0]  o_owner,
  output logic        o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_DWELL} state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic [15:0] w_data_nxt;
  logic        w_we_nxt;
  logic [3:0]  w_gnt_nxt;
  logic [1:0]  w_owner_nxt;

  logic [1:0]  w_start;
  logic [2:0]  w_pick_all, w_pick_oth;
  logic        w_own_req;
  logic [15:0] w_own_data, w_win_data;
  logic        w_do_grant, w_pre;
  logic [1:0]  w_win;

  // Returns {found, index}: first set request scanning upward (mod 4) from start.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
    logic [1:0] idx;
    rr_pick = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = start + 2'(i);
      if (!rr_pick[2] && req[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

  assign w_start    = o_owner + 2'd1;
  assign w_pick_all = rr_pick(i_req, w_start);
  assign w_pick_oth = rr_pick(i_req & ~(4'b0001 << o_owner), w_start);
  assign w_own_req  = i_req[o_owner];
  assign w_own_data = i_data[{o_owner, 4'b0000} +: 16];
  assign w_win_data = i_data[{w_win, 4'b0000} +: 16];
  assign o_busy     = (r_state != S_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_data_nxt  = o_data;
    w_we_nxt    = 1'b0;
    w_gnt_nxt   = o_gnt;
    w_owner_nxt = o_owner;
    w_do_grant  = 1'b0;
    w_win       = '0;
    w_pre       = 1'b0;
`ifdef HEX_DISP_ARB_PRIO_EN
    w_pre       = i_req[0] && (o_owner != 2'd0);
`endif

    case (r_state)
      S_IDLE: begin
        if (|i_req) begin
          w_do_grant = 1'b1;
          w_win      = w_pick_all[1:0];
`ifdef HEX_DISP_ARB_PRIO_EN
          if (i_req[0]) w_win = 2'd0;
`endif
        end
      end

      S_GRANT: begin
        w_state_nxt = S_DWELL;
        w_cnt_nxt   = 16'(DWELL_CYCLES - 1);
      end

      S_DWELL: begin
        if (w_pre) begin
          w_do_grant = 1'b1;
          w_win      = 2'd0;
        end else if (r_cnt == '0) begin
          if (w_pick_oth[2]) begin
            w_do_grant = 1'b1;
            w_win      = w_pick_oth[1:0];
          end else if (w_own_req) begin
            w_cnt_nxt = 16'(DWELL_CYCLES - 1);
          end else begin
            w_state_nxt = S_IDLE;
            w_gnt_nxt   = '0;
          end
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end

        // Owner data refresh only while ownership continues; counter is untouched.
        if (!w_do_grant && (w_state_nxt == S_DWELL) && w_own_req && (w_own_data != o_data)) begin
          w_data_nxt = w_own_data;
          w_we_nxt   = 1'b1;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase

    if (w_do_grant) begin
      w_state_nxt = S_GRANT;
      w_gnt_nxt   = 4'b0001 << w_win;
      w_owner_nxt = w_win;
      w_data_nxt  = w_win_data;
      w_we_nxt    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      o_data  <= '0;
      o_we    <= 1'b0;
      o_gnt   <= '0;
      o_owner <= 2'd3;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      o_data  <= w_data_nxt;
      o_we    <= w_we_nxt;
      o_gnt   <= w_gnt_nxt;
      o_owner <= w_owner_nxt;
    end
  end

endmodule

// File: tb/tb_hex_disp_arb.sv
// Directed bench for hex_disp_arb (DWELL_CYCLES = 4): stimulus queues expected writes,
// a monitor pops and compares them whenever o_we is seen.
module tb_hex_disp_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  i_req;
  logic [63:0] i_data;
  logic [15:0] o_data;
  logic        o_we;
  logic [3:0]  o_gnt;
  logic [1:0]  o_owner;
  logic        o_busy;

  hex_disp_arb #(.DWELL_CYCLES(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_req  (i_req),
    .i_data (i_data),
    .o_data (o_data),
    .o_we   (o_we),
    .o_gnt  (o_gnt),
    .o_owner(o_owner),
    .o_busy (o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  g;
    logic [1:0]  o;
    int          c;
  } wr_t;

  wr_t exp_q[$];
  int  cyc = 0;
  int  ntests = 0;
  int  nfail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write strobe must match the next queued expectation.
  always @(posedge clk) begin
    #1;
    if (o_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_we", {o_data, 12'h0, o_gnt}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("we_data",  32'(o_data),  32'(e.d));
        chk("we_gnt",   32'(o_gnt),   32'(e.g));
        chk("we_owner", 32'(o_owner), 32'(e.o));
        chk("we_cycle", 32'(cyc),     32'(e.c));
      end
    end
  end

  task automatic push(input logic [15:0] d, input logic [3:0] g, input logic [1:0] o, input int c);
    wr_t e;
    e.d = d; e.g = g; e.o = o; e.c = c;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    i_req = '0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (o_busy === 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(o_busy), 32'd0);
  endtask

  int c0;
  int nbusy;

  initial begin
    rst_n  = 1'b0;
    i_req  = '0;
    i_data = '0;
    step(2);

    // Reset values
    chk("rst_data",  32'(o_data),  32'h0);
    chk("rst_we",    32'(o_we),    32'h0);
    chk("rst_gnt",   32'(o_gnt),   32'h0);
    chk("rst_owner", 32'(o_owner), 32'h3);
    chk("rst_busy",  32'(o_busy),  32'h0);
    rst_n = 1'b1;
    step(1);

    // Single request, BEEF on requester 2
    i_data[47:32] = 16'hBEEF;
    i_req = 4'b0100;
    c0 = cyc;
    push(16'hBEEF, 4'b0100, 2'd2, c0 + 1);
    nbusy = 0;
    step(1);
    i_req = '0;
    while (o_busy === 1'b1 && nbusy < 20) begin
      nbusy++;
      step(1);
    end
    chk("busy_len",   32'(nbusy),   32'd5);
    chk("idle_gnt",   32'(o_gnt),   32'h0);
    chk("idle_data",  32'(o_data),  32'hBEEF);
    chk("idle_owner", 32'(o_owner), 32'd2);

    // All four requesting: rotation 0,1,2,3,0, five cycles each
    do_reset();
    for (int k = 0; k < 4; k++) i_data[16*k +: 16] = 16'hA000 + 16'(k);
    i_req = 4'b1111;
    c0 = cyc;
    push(16'hA000, 4'b0001, 2'd0, c0 + 1);
    push(16'hA001, 4'b0010, 2'd1, c0 + 6);
    push(16'hA002, 4'b0100, 2'd2, c0 + 11);
    push(16'hA003, 4'b1000, 2'd3, c0 + 16);
    push(16'hA000, 4'b0001, 2'd0, c0 + 21);
    for (int i = 1; i <= 25; i++) begin
      step(1);
      chk("rr_gnt", 32'(o_gnt), 32'(4'b0001 << (((i - 1) / 5) % 4)));
    end
    i_req = '0;
    wait_idle();

    // Owner 1 changes data mid-dwell: one strobe, expiry time unchanged
    i_data[31:16] = 16'h1234;
    i_req = 4'b0010;
    c0 = cyc;
    push(16'h1234, 4'b0010, 2'd1, c0 + 1);
    step(2);
    i_data[31:16] = 16'h1235;
    push(16'h1235, 4'b0010, 2'd1, c0 + 3);
    step(1);
    chk("chg_gnt", 32'(o_gnt), 32'h2);
    step(1);
    i_req = '0;
    step(1);
    chk("chg_busy_d0", 32'(o_busy), 32'd1);
    step(1);
    chk("chg_busy_end", 32'(o_busy), 32'd0);
    chk("chg_data",     32'(o_data), 32'h1235);

    // Owner 2 alone: reload without strobe, then drop mid-dwell
    i_data[47:32] = 16'hC0DE;
    i_req = 4'b0100;
    c0 = cyc;
    push(16'hC0DE, 4'b0100, 2'd2, c0 + 1);
    step(5);
    for (int i = 6; i <= 9; i++) begin
      step(1);
      if (i == 7) i_req = '0;
      chk("drop_gnt_held", 32'(o_gnt), 32'h4);
    end
    step(1);
    chk("drop_gnt_idle", 32'(o_gnt),   32'h0);
    chk("drop_busy",     32'(o_busy),  32'd0);
    chk("drop_data",     32'(o_data),  32'hC0DE);
    chk("drop_owner",    32'(o_owner), 32'd2);

    // Owner 3 dwelling when requester 0 arrives
    i_data[63:48] = 16'h3333;
    i_data[15:0]  = 16'h0F0F;
    i_req = 4'b1000;
    c0 = cyc;
    push(16'h3333, 4'b1000, 2'd3, c0 + 1);
    step(2);
    i_req = 4'b1001;
`ifdef HEX_DISP_ARB_PRIO_EN
    push(16'h0F0F, 4'b0001, 2'd0, c0 + 3);
    step(1);
    chk("pre_gnt", 32'(o_gnt), 32'h1);
    i_req = '0;
`else
    push(16'h0F0F, 4'b0001, 2'd0, c0 + 6);
    step(1);
    chk("pre_gnt", 32'(o_gnt), 32'h8);
    step(2);
    chk("pre_wait_gnt", 32'(o_gnt), 32'h8);
    step(1);
    chk("pre_exp_gnt", 32'(o_gnt), 32'h1);
    i_req = '0;
`endif
    wait_idle();

    // Asynchronous reset mid-dwell, then 1010 grants requester 1
    i_data[47:32] = 16'h2222;
    i_req = 4'b0100;
    c0 = cyc;
    push(16'h2222, 4'b0100, 2'd2, c0 + 1);
    step(3);
    rst_n = 1'b0;
    i_req = '0;
    #1;
    chk("arst_data",  32'(o_data),  32'h0);
    chk("arst_we",    32'(o_we),    32'h0);
    chk("arst_gnt",   32'(o_gnt),   32'h0);
    chk("arst_owner", 32'(o_owner), 32'h3);
    chk("arst_busy",  32'(o_busy),  32'h0);
    step(2);
    rst_n = 1'b1;
    i_data[31:16] = 16'h1111;
    i_data[63:48] = 16'h3333;
    i_req = 4'b1010;
    c0 = cyc;
    push(16'h1111, 4'b0010, 2'd1, c0 + 1);
    step(1);
    chk("arst_first_gnt", 32'(o_gnt), 32'h2);
    i_req = '0;
    wait_idle();

    step(3);
    chk("leftover_writes", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
